// File: rtl/sign_collator_pkg.sv
// Shared widths, helper functions and record layout for the sign collator.
package sign_collator_pkg;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_NUM_GROUPS = 6;

  function automatic int cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int gw(input int groups);
    return $clog2(groups);
  endfunction

  function automatic int rec_w(input int depth, input int groups);
    return depth + depth * gw(groups) + cw(depth) * (groups + 1) + 2;
  endfunction

  localparam int DEF_CW = cw(DEF_DEPTH);
  localparam int DEF_GW = gw(DEF_NUM_GROUPS);

  // Field order matches the flattened queue bus (MSB first).
  typedef struct packed {
    logic                                     slice_last;
    logic                                     overflow;
    logic [DEF_NUM_GROUPS-1:0][DEF_CW-1:0]    grp_cnt;
    logic [DEF_CW-1:0]                        count;
    logic [DEF_DEPTH-1:0][DEF_GW-1:0]         tags;
    logic [DEF_DEPTH-1:0]                     bits;
  } mb_rec_t;
endpackage

// File: rtl/sign_collator_recq.sv
// Two-entry record FIFO; entry 0 is always the registered head.
module sign_collator_recq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] e0, e1;
  logic [1:0]   occ;
  logic         push_ok, pop_ok;

  assign full    = (occ == 2'd2);
  assign empty   = (occ == 2'd0);
  assign pop_ok  = pop & !empty;
  assign push_ok = push & (!full | pop_ok);
  assign dout    = e0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= 2'd0;
    end else begin
      if (pop_ok) begin
        if (occ == 2'd2) begin
          e0 <= e1;
          if (push_ok) e1 <= din;
        end else if (push_ok) begin
          e0 <= din;
        end
      end else if (push_ok) begin
        if (occ == 2'd0) e0 <= din;
        else             e1 <= din;
      end
      occ <= occ + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end
endmodule

// File: rtl/sign_collator_pq.sv
// Collects per-macroblock sign bits with group tags and queues finished records.
module sign_collator_pq import sign_collator_pkg::*; #(
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int NUM_GROUPS = DEF_NUM_GROUPS,
  localparam int CW         = cw(DEPTH),
  localparam int GW         = gw(NUM_GROUPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     sign_en,
  input  logic                     sign_bit,
  input  logic                     group_change,
  input  logic                     macroblock_end,
  input  logic                     slice_end,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH-1:0]         mb_bits,
  output logic [DEPTH*GW-1:0]      mb_tag,
  output logic [CW-1:0]            mb_count,
  output logic [NUM_GROUPS*CW-1:0] mb_group_cnt,
  output logic                     mb_overflow,
  output logic                     mb_slice_last,
  output logic                     err_protocol
);
  localparam int RW = rec_w(DEPTH, NUM_GROUPS);

  logic [DEPTH-1:0]               bits_q, bits_d;
  logic [DEPTH-1:0][GW-1:0]       tags_q, tags_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [NUM_GROUPS-1:0][CW-1:0]  gcnt_q, gcnt_d;
  logic                           ovf_q, ovf_d;
  logic [GW-1:0]                  g_q, g_d;
  logic                           err_q, err_set;
  logic                           full, empty, push, pop, accept, end_ev;
  logic [RW-1:0]                  din, dout;

  assign out_valid    = !empty;
  assign pop          = clk_en & out_valid & out_ready;
  assign in_ready     = !full | (out_valid & out_ready);
  assign accept       = clk_en & in_ready;
  assign end_ev       = accept & (macroblock_end | slice_end);
  assign push         = end_ev;
  assign err_protocol = err_q;

  // Next-accumulator view includes this cycle's sign, so a sign arriving with
  // an end event lands in the record being closed.
  always_comb begin
    bits_d  = bits_q;
    tags_d  = tags_q;
    count_d = count_q;
    gcnt_d  = gcnt_q;
    ovf_d   = ovf_q;
    g_d     = g_q;
    err_set = 1'b0;
    if (accept & sign_en) begin
      if (count_q < CW'(DEPTH)) begin
        bits_d[count_q[CW-2:0]] = sign_bit;
        tags_d[count_q[CW-2:0]] = g_q;
        count_d                 = count_q + CW'(1);
        gcnt_d[g_q]             = gcnt_q[g_q] + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (accept & group_change & !end_ev) begin
      if (g_q == GW'(NUM_GROUPS - 1)) err_set = 1'b1;
      else                             g_d     = g_q + GW'(1);
    end
    if (end_ev) g_d = '0;
    if (clk_en & !in_ready & (sign_en | group_change | macroblock_end | slice_end))
      err_set = 1'b1;
  end

  assign din = {slice_end, ovf_d, gcnt_d, count_d, tags_d, bits_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q  <= '0;
      tags_q  <= '0;
      count_q <= '0;
      gcnt_q  <= '0;
      ovf_q   <= 1'b0;
      g_q     <= '0;
      err_q   <= 1'b0;
    end else if (clk_en) begin
      err_q <= err_q | err_set;
      g_q   <= g_d;
      if (end_ev) begin
        bits_q  <= '0;
        tags_q  <= '0;
        count_q <= '0;
        gcnt_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        bits_q  <= bits_d;
        tags_q  <= tags_d;
        count_q <= count_d;
        gcnt_q  <= gcnt_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  sign_collator_recq #(.W(RW)) u_recq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign {mb_slice_last, mb_overflow, mb_group_cnt, mb_count, mb_tag, mb_bits} = dout;
endmodule

// File: tb/tb_sign_collator_pq.sv
// Directed bench for sign_collator_pq: default 64/6 build plus a 128/8 build.
module tb_sign_collator_pq;
  logic clk = 1'b0;
  logic rst, clk_en;
  logic se, sb, gc, mbe, sle, ordy;
  logic irdy, ov, ovf, sl, err;
  logic [63:0]  bits;
  logic [191:0] tag;
  logic [6:0]   cnt;
  logic [41:0]  gcnt;
  logic se8, sb8, gc8, mbe8, sle8, ordy8;
  logic irdy8, ov8, ovf8, sl8, err8;
  logic [127:0] bits8;
  logic [383:0] tag8;
  logic [7:0]   cnt8;
  logic [63:0]  gcnt8;
  logic [511:0] e;
  int checks = 0, errors = 0, sidx = 0;

  always #5 clk = ~clk;

  sign_collator_pq dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sign_en(se), .sign_bit(sb),
    .group_change(gc), .macroblock_end(mbe), .slice_end(sle), .in_ready(irdy),
    .out_valid(ov), .out_ready(ordy), .mb_bits(bits), .mb_tag(tag), .mb_count(cnt),
    .mb_group_cnt(gcnt), .mb_overflow(ovf), .mb_slice_last(sl), .err_protocol(err));

  sign_collator_pq #(.DEPTH(128), .NUM_GROUPS(8)) dut8 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sign_en(se8), .sign_bit(sb8),
    .group_change(gc8), .macroblock_end(mbe8), .slice_end(sle8), .in_ready(irdy8),
    .out_valid(ov8), .out_ready(ordy8), .mb_bits(bits8), .mb_tag(tag8), .mb_count(cnt8),
    .mb_group_cnt(gcnt8), .mb_overflow(ovf8), .mb_slice_last(sl8), .err_protocol(err8));

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int s, input int b, input int g, input int m, input int l);
    se = (s != 0); sb = (b != 0); gc = (g != 0); mbe = (m != 0); sle = (l != 0);
    cyc();
    se = 1'b0; gc = 1'b0; mbe = 1'b0; sle = 1'b0;
  endtask

  task automatic step8(input int s, input int b, input int g, input int l);
    se8 = (s != 0); sb8 = (b != 0); gc8 = (g != 0); sle8 = (l != 0);
    cyc();
    se8 = 1'b0; gc8 = 1'b0; sle8 = 1'b0;
  endtask

  // b==2 gives an alternating pattern: bit i of the record = i odd
  task automatic signs(input int n, input int b);
    for (int k = 0; k < n; k++) begin
      step(1, (b == 2) ? (sidx % 2) : b, 0, 0, 0);
      sidx++;
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; ordy = 1'b1; ordy8 = 1'b1;
    se = 0; sb = 0; gc = 0; mbe = 0; sle = 0;
    se8 = 0; sb8 = 0; gc8 = 0; mbe8 = 0; sle8 = 0;
    #13;
    chk("rst_in_ready", 512'(irdy), 512'(1));
    chk("rst_out_valid", 512'(ov), 512'(0));
    chk("rst_mb_fields", 512'({bits, cnt, gcnt, ovf, sl}), 512'(0));
    chk("rst_tag", 512'(tag), 512'(0));
    chk("rst_err", 512'(err), 512'(0));
    rst = 1'b0;
    cyc();

    // Groups 0,3,4,0,31,26
    sidx = 0;
    step(0, 0, 1, 0, 0); signs(3, 2);
    step(0, 0, 1, 0, 0); signs(4, 2);
    step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0); signs(31, 2);
    step(0, 0, 1, 0, 0); signs(26, 2);
    step(0, 0, 0, 1, 0);
    chk("t1_valid", 512'(ov), 512'(1));
    chk("t1_count", 512'(cnt), 512'(64));
    chk("t1_grp", 512'(gcnt), 512'({7'd26, 7'd31, 7'd0, 7'd4, 7'd3, 7'd0}));
    chk("t1_ovf_sl", 512'({ovf, sl}), 512'(0));
    chk("t1_bits", 512'(bits), 512'(64'hAAAA_AAAA_AAAA_AAAA));
    e = '0;
    for (int i = 0; i < 64; i++) e[i*3 +: 3] = (i < 3) ? 3'd1 : (i < 7) ? 3'd2 : (i < 38) ? 3'd4 : 3'd5;
    chk("t1_tag", 512'(tag), e);
    cyc();
    chk("t1_drained", 512'(ov), 512'(0));

    // Overflow: 4 then 64 signs
    signs(4, 1); step(0, 0, 1, 0, 0); signs(64, 1);
    chk("t2_in_ready", 512'(irdy), 512'(1));
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t2_count", 512'(cnt), 512'(64));
    chk("t2_grp", 512'(gcnt), 512'({7'd0, 7'd0, 7'd0, 7'd0, 7'd60, 7'd4}));
    chk("t2_ovf", 512'(ovf), 512'(1));
    chk("t2_bits", 512'(bits), 512'({64{1'b1}}));
    e = '0;
    for (int i = 4; i < 64; i++) e[i*3 +: 3] = 3'd1;
    chk("t2_tag", 512'(tag), e);
    cyc();

    // Empty macroblocks back to back; second with both end strobes
    step(0, 0, 0, 1, 0);
    chk("e1_rec", 512'({ov, cnt, gcnt, ovf, sl, bits}), 512'({1'b1, 7'd0, 42'd0, 1'b0, 1'b0, 64'd0}));
    step(0, 0, 0, 1, 1);
    chk("e2_rec", 512'({ov, cnt, gcnt, ovf, sl}), 512'({1'b1, 7'd0, 42'd0, 1'b0, 1'b1}));
    cyc();
    chk("e2_drained", 512'(ov), 512'(0));

    // Backpressure over three macroblocks
    chk("t3_err_pre", 512'(err), 512'(0));
    ordy = 1'b0;
    step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0);
    chk("t3_ready_one", 512'(irdy), 512'(1));
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(0, 0, 0, 1, 0);
    chk("t3_ready_full", 512'(irdy), 512'(0));
    step(1, 1, 0, 0, 0); step(0, 0, 0, 1, 0);
    chk("t3_err", 512'(err), 512'(1));
    chk("t3_head_a", 512'({ov, cnt, bits}), 512'({1'b1, 7'd2, 64'd1}));
    ordy = 1'b1;
    cyc();
    chk("t3_head_b", 512'({ov, cnt, gcnt, bits}), 512'({1'b1, 7'd3, 42'd3, 64'd6}));
    cyc();
    chk("t3_drained", 512'(ov), 512'(0));
    step(0, 0, 0, 1, 0);
    chk("t3_no_leak", 512'({ov, cnt}), 512'({1'b1, 7'd0}));
    cyc();

    // Sign + group_change + macroblock_end in one cycle
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("t5_rec", 512'({cnt, gcnt, bits}), 512'({7'd3, 42'h82, 64'd4}));
    chk("t5_tag", 512'(tag), 512'(64));
    step(1, 1, 0, 0, 0); step(0, 0, 0, 1, 0);
    chk("t5_next_g0", 512'({cnt, gcnt, tag}), 512'({7'd1, 42'd1, 192'd0}));
    cyc();

    // clk_en low for 5 cycles with every input active
    signs(10, 1); step(0, 0, 1, 0, 0);
    clk_en = 1'b0; se = 1; sb = 0; gc = 1; mbe = 1;
    repeat (5) cyc();
    chk("t6_hold", 512'(ov), 512'(0));
    se = 0; gc = 0; mbe = 0; clk_en = 1'b1;
    signs(5, 1); step(0, 0, 0, 1, 0);
    chk("t6_rec", 512'({cnt, gcnt, bits}), 512'({7'd15, 42'd650, 64'h7FFF}));
    e = '0;
    for (int i = 10; i < 15; i++) e[i*3 +: 3] = 3'd1;
    chk("t6_tag", 512'(tag), e);
    cyc();

    // 128/8 build: 8 groups x 16 signs, slice_end
    sidx = 0;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 16; k++) begin
        step8(1, (sidx % 3 == 0) ? 1 : 0, 0, 0);
        sidx++;
      end
      if (g < 7) step8(0, 0, 1, 0);
    end
    step8(0, 0, 0, 1);
    chk("t4_valid", 512'({ov8, irdy8}), 512'({1'b1, 1'b1}));
    chk("t4_count", 512'(cnt8), 512'(128));
    e = '0;
    for (int i = 0; i < 8; i++) e[i*8 +: 8] = 8'd16;
    chk("t4_grp", 512'(gcnt8), e);
    chk("t4_flags", 512'({sl8, ovf8, err8}), 512'({1'b1, 1'b0, 1'b0}));
    e = '0;
    for (int i = 0; i < 128; i++) e[i] = (i % 3 == 0);
    chk("t4_bits", 512'(bits8), e);
    e = '0;
    for (int i = 0; i < 128; i++) e[i*3 +: 3] = 3'(i / 16);
    chk("t4_tag", 512'(tag8), e);
    for (int k = 0; k < 7; k++) step8(0, 0, 1, 0);
    chk("t4_last_group_ok", 512'(err8), 512'(0));
    step8(0, 0, 1, 0);
    chk("t4_group_overrun", 512'(err8), 512'(1));

    // Asynchronous reset mid-macroblock
    signs(3, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst2_state", 512'({irdy, ov, err, err8, cnt}), 512'({1'b1, 1'b0, 1'b0, 1'b0, 7'd0}));
    rst = 1'b0;
    cyc();
    step(0, 0, 0, 1, 0);
    chk("rst2_discard", 512'({ov, cnt, gcnt}), 512'({1'b1, 7'd0, 42'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
